fifo_burst_reader: RTL and testbench

Read-side engine for the team's synchronous FIFO. On a `start` pulse it pops exactly `burst_len` words from the FIFO and presents them on a valid/ready output stream. It absorbs the FIFO RAM's one-cycle registered read latency and downstream back-pressure with a 2-entry skid buffer, so it never over-pops and never drops a word. It sits between the FIFO read port and any stream consumer: serializer, DMA packer or test sink.

---
 rtl/fifo_burst_reader_if.sv | 22 ++
 rtl/fifo_burst_reader.sv | 114 +++++++++++
 tb/tb_fifo_burst_reader.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_burst_reader_if.sv
// FIFO read port plus valid/ready output stream seen by fifo_burst_reader.
// The master modport is the reader; the slave modport is the FIFO and the consumer.
interface fifo_burst_reader_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  fifo_empty;
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;

    modport master (
        input  fifo_empty, fifo_rd_data, m_ready,
        output fifo_rd_en, m_valid, m_data
    );

    modport slave (
        output fifo_empty, fifo_rd_data, m_ready,
        input  fifo_rd_en, m_valid, m_data
    );
endinterface

// File: rtl/fifo_burst_reader.sv
// Pops exactly burst_len words from a registered-read FIFO and streams them out
// through a 2-entry skid buffer that hides read latency and back-pressure.
module fifo_burst_reader #(
    parameter int DATA_WIDTH  = 8,
    parameter int BURST_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [BURST_WIDTH-1:0] burst_len,
    output logic                   busy,
    output logic                   done,
    fifo_burst_reader_if.master    bus
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_e;

    state_e                 state_q, state_d;
    logic [BURST_WIDTH-1:0] len_q, len_d;
    logic [BURST_WIDTH-1:0] issued_q, issued_d;
    logic [BURST_WIDTH-1:0] delivered_q, delivered_d;
    logic [1:0]             occ_q, occ_d;
    logic                   pending_q, pending_d;
    logic                   done_q, done_d;
    logic [DATA_WIDTH-1:0]  skid_q [2];
    logic [DATA_WIDTH-1:0]  skid_d [2];

    logic handshake;
    logic credit;
    logic rd_en;

    // A pop is allowed only if its word is guaranteed a skid slot when it lands.
    assign handshake = (occ_q != 2'd0) && bus.m_ready;
    assign credit    = ((occ_q + {1'b0, pending_q}) < 2'd2) || handshake;
    assign rd_en     = (state_q == READ) && !bus.fifo_empty && (issued_q != len_q) && credit;

    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    always_comb begin
        skid_d = skid_q;
        occ_d  = occ_q;
        if (handshake) begin
            skid_d[0] = skid_q[1];
            occ_d     = occ_q - 2'd1;
        end
        if (pending_q) begin
            skid_d[occ_d[0]] = bus.fifo_rd_data;
            occ_d            = occ_d + 2'd1;
        end
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        issued_d    = rd_en ? issued_q + BURST_WIDTH'(1) : issued_q;
        delivered_d = handshake ? delivered_q + BURST_WIDTH'(1) : delivered_q;
        pending_d   = rd_en;
        done_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (burst_len != '0) begin
                        len_d       = burst_len;
                        issued_d    = '0;
                        delivered_d = '0;
                        state_d     = READ;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            READ: begin
                if (issued_q == len_q) state_d = DRAIN;
            end
            DRAIN: begin
                // Judged on next-cycle values so done lands on the cycle right after the last handshake.
                if ((occ_d == 2'd0) && !pending_d && (delivered_d == len_q)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            len_q       <= '0;
            issued_q    <= '0;
            delivered_q <= '0;
            occ_q       <= 2'd0;
            pending_q   <= 1'b0;
            done_q      <= 1'b0;
            // NOTE: the skid entries are reset too, since m_data is the head entry and must read 0 out of reset.
            skid_q[0]   <= '0;
            skid_q[1]   <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            issued_q    <= issued_d;
            delivered_q <= delivered_d;
            occ_q       <= occ_d;
            pending_q   <= pending_d;
            done_q      <= done_d;
            skid_q      <= skid_d;
        end
    end

    assign busy           = (state_q != IDLE);
    assign done           = done_q;
    assign bus.fifo_rd_en = rd_en;
    assign bus.m_valid    = (occ_q != 2'd0);
    assign bus.m_data     = skid_q[0];
endmodule

// File: tb/tb_fifo_burst_reader.sv
// Self-checking bench for fifo_burst_reader: behavioural FIFO with registered read,
// table of plain bursts, then hand-written back-pressure, underflow, busy-start and reset sequences.
module tb_fifo_burst_reader;
    localparam int DW = 8;
    localparam int BW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [BW-1:0] burst_len;
    logic          busy;
    logic          done;

    fifo_burst_reader_if #(.DATA_WIDTH(DW)) bus ();

    fifo_burst_reader #(.DATA_WIDTH(DW), .BURST_WIDTH(BW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .burst_len (burst_len),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // Behavioural FIFO: pop on rd_en, data appears the following cycle.
    logic [DW-1:0] fifo_mem [$];
    int            fifo_count = 0;
    logic          wr_en;
    logic          fifo_clr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] rd_data_q = '0;

    always @(posedge clk) begin
        if (fifo_clr) begin
            fifo_mem.delete();
        end else begin
            if (bus.fifo_rd_en && fifo_mem.size() != 0) rd_data_q <= fifo_mem.pop_front();
            if (wr_en) fifo_mem.push_back(wr_data);
        end
        fifo_count <= fifo_mem.size();
    end

    assign bus.fifo_rd_data = rd_data_q;
    assign bus.fifo_empty   = (fifo_count == 0);

    typedef struct {
        int len;
        int preload;
        int done_cyc;
        int busy_cyc;
    } row_t;

    row_t          rows [5];
    logic [DW-1:0] exp_q [$];

    int   checks = 0;
    int   failures = 0;
    int   pops = 0, delivs = 0, dones = 0, pops_lo = 0;
    int   empty_viol = 0, stall_viol = 0, peak = 0;
    logic s_done, s_busy, s_rd;
    logic prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;

    int done_cyc, busy_cnt, first_rd, last_rd, busy_gap, rd_at7, consumed;
    int p0, d0, dl0, lo0, ev0, sv0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
        end
    endtask

    // One clock: sample at the falling edge, score deliveries, return 1ns after the rising edge.
    task automatic tick();
        logic          hs;
        int            inflight;
        logic [DW-1:0] e;
        @(negedge clk);
        s_done   = done;
        s_busy   = busy;
        s_rd     = bus.fifo_rd_en;
        hs       = bus.m_valid && bus.m_ready;
        inflight = pops - delivs;
        if (inflight > peak) peak = inflight;
        if (prev_stall && (!bus.m_valid || bus.m_data !== prev_data)) stall_viol++;
        prev_stall = bus.m_valid && !bus.m_ready;
        prev_data  = bus.m_data;
        if (s_rd) begin
            pops++;
            if (bus.fifo_empty) empty_viol++;
            if (!bus.m_ready) pops_lo++;
        end
        if (hs) begin
            delivs++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_extra_word got=0x%0h exp=none", bus.m_data);
            end else begin
                e = exp_q.pop_front();
                check("sb_data", 32'(bus.m_data), 32'(e));
            end
        end
        if (s_done) dones++;
        @(posedge clk);
        #1;
    endtask

    task automatic fifo_reset();
        fifo_clr = 1'b1;
        tick();
        fifo_clr = 1'b0;
    endtask

    task automatic preload(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            wr_en   = 1'b1;
            wr_data = base + DW'(i);
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic pulse_start(input int len);
        start     = 1'b1;
        burst_len = BW'(len);
        tick();
        start     = 1'b0;
    endtask

    initial begin
        rows[0] = '{len: 0, preload: 3,  done_cyc: 1,  busy_cyc: 0};
        rows[1] = '{len: 4, preload: 10, done_cyc: 7,  busy_cyc: 6};
        rows[2] = '{len: 1, preload: 1,  done_cyc: 4,  busy_cyc: 3};
        rows[3] = '{len: 3, preload: 5,  done_cyc: 6,  busy_cyc: 5};
        rows[4] = '{len: 7, preload: 7,  done_cyc: 10, busy_cyc: 9};

        rst         = 1'b1;
        start       = 1'b0;
        burst_len   = '0;
        wr_en       = 1'b0;
        wr_data     = '0;
        fifo_clr    = 1'b0;
        bus.m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", 32'({busy, done, bus.fifo_rd_en, bus.m_valid, bus.m_data}), 32'h0);
        rst = 1'b0;
        tick();

        for (int r = 0; r < 5; r++) begin
            fifo_reset();
            preload(rows[r].preload, DW'(r * 16));
            exp_q.delete();
            for (int i = 0; i < rows[r].len; i++) exp_q.push_back(DW'(r * 16 + i));
            p0 = pops; d0 = dones;
            done_cyc = -1; busy_cnt = 0; first_rd = -1; last_rd = -1;
            pulse_start(rows[r].len);
            for (int c = 1; c <= rows[r].len + 8; c++) begin
                tick();
                if (s_done && done_cyc < 0) done_cyc = c;
                if (s_busy) busy_cnt++;
                if (s_rd) begin
                    if (first_rd < 0) first_rd = c;
                    last_rd = c;
                end
            end
            check($sformatf("row%0d_done_cycle", r), done_cyc, rows[r].done_cyc);
            check($sformatf("row%0d_done_pulses", r), dones - d0, 1);
            check($sformatf("row%0d_busy_cycles", r), busy_cnt, rows[r].busy_cyc);
            check($sformatf("row%0d_pops", r), pops - p0, rows[r].len);
            check($sformatf("row%0d_fifo_left", r), fifo_count, rows[r].preload - rows[r].len);
            check($sformatf("row%0d_words_missing", r), exp_q.size(), 0);
            check($sformatf("row%0d_first_rd", r), first_rd, (rows[r].len == 0) ? -1 : 1);
            check($sformatf("row%0d_last_rd", r), last_rd, (rows[r].len == 0) ? -1 : rows[r].len);
        end

        // Back-pressure: consumer stalls in cycles 4..9.
        fifo_reset();
        preload(10, 8'h00);
        exp_q.delete();
        for (int i = 0; i < 6; i++) exp_q.push_back(DW'(i));
        peak = 0; p0 = pops; d0 = dones; lo0 = pops_lo; sv0 = stall_viol;
        pulse_start(6);
        for (int c = 1; c <= 30; c++) begin
            bus.m_ready = !(c >= 4 && c <= 9);
            tick();
        end
        bus.m_ready = 1'b1;
        check("bp_peak_in_flight", peak, 2);
        check("bp_pops_while_stalled_le2", 32'((pops_lo - lo0) <= 2), 1);
        check("bp_pops", pops - p0, 6);
        check("bp_done_pulses", dones - d0, 1);
        check("bp_words_missing", exp_q.size(), 0);
        check("bp_output_held", stall_viol - sv0, 0);

        // Underflow: two words up front, three more written in cycles 6..8.
        fifo_reset();
        preload(2, 8'h80);
        exp_q.delete();
        for (int i = 0; i < 5; i++) exp_q.push_back(DW'(8'h80 + i));
        p0 = pops; d0 = dones; ev0 = empty_viol;
        done_cyc = -1; busy_gap = 0; rd_at7 = 0;
        pulse_start(5);
        for (int c = 1; c <= 40; c++) begin
            wr_en   = (c >= 6 && c <= 8);
            wr_data = DW'(8'h82 + c - 6);
            tick();
            if (s_done && done_cyc < 0) done_cyc = c;
            if (done_cyc < 0 && !s_busy) busy_gap++;
            if (c == 7) rd_at7 = int'(s_rd);
        end
        wr_en = 1'b0;
        check("uf_rd_while_empty", empty_viol - ev0, 0);
        check("uf_resume_same_cycle", rd_at7, 1);
        check("uf_busy_dropped", busy_gap, 0);
        check("uf_pops", pops - p0, 5);
        check("uf_done_cycle", done_cyc, 12);
        check("uf_done_pulses", dones - d0, 1);
        check("uf_words_missing", exp_q.size(), 0);

        // Start with burst_len=9 arriving during a 3-word burst must be ignored.
        fifo_reset();
        preload(10, 8'hC0);
        exp_q.delete();
        for (int i = 0; i < 3; i++) exp_q.push_back(DW'(8'hC0 + i));
        p0 = pops; d0 = dones; done_cyc = -1;
        pulse_start(3);
        for (int c = 1; c <= 15; c++) begin
            start = (c == 2);
            if (c == 2) burst_len = BW'(9);
            tick();
            if (s_done && done_cyc < 0) done_cyc = c;
        end
        start = 1'b0;
        check("sb_pops", pops - p0, 3);
        check("sb_done_pulses", dones - d0, 1);
        check("sb_done_cycle", done_cyc, 6);
        check("sb_fifo_left", fifo_count, 7);
        check("sb_words_missing", exp_q.size(), 0);

        // Reset after three of eight words have been delivered.
        fifo_reset();
        preload(10, 8'h40);
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(DW'(8'h40 + i));
        p0 = pops; dl0 = delivs; d0 = dones;
        pulse_start(8);
        for (int c = 0; c < 20 && (delivs - dl0) < 3; c++) tick();
        check("rst_three_delivered", delivs - dl0, 3);
        rst = 1'b1;
        #1;
        check("rst_outputs_cleared", 32'({busy, done, bus.fifo_rd_en, bus.m_valid, bus.m_data}), 32'h0);
        consumed = pops - p0;
        exp_q.delete();
        tick();
        tick();
        rst        = 1'b0;
        delivs     = pops;
        prev_stall = 1'b0;
        tick();
        check("rst_no_done", dones - d0, 0);
        for (int i = 0; i < 2; i++) exp_q.push_back(DW'(8'h40 + consumed + i));
        p0 = pops; d0 = dones; done_cyc = -1;
        pulse_start(2);
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (s_done && done_cyc < 0) done_cyc = c;
        end
        check("post_rst_done_cycle", done_cyc, 5);
        check("post_rst_done_pulses", dones - d0, 1);
        check("post_rst_pops", pops - p0, 2);
        check("post_rst_words_missing", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
